// File: rtl/dtw_query_sequencer.sv
// Purpose: buffers one query, clears the DTW core, streams query+reference into it, returns min score/position.
// Latency: start to result_valid = 2*SQG_SIZE + ref_len + 5 cycles with sqg_valid held high.
// Backpressure: sqg_ready only in LOAD (unlimited sqg_valid stalls); result held in REPORT until result_ready.
module dtw_query_sequencer #(
    parameter int width    = 16,
    parameter int SQG_SIZE = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ref_len_in,
    input  logic             sqg_valid,
    output logic             sqg_ready,
    input  logic [width-1:0] sqg_data,
    output logic             ref_en,
    output logic [31:0]      ref_addr,
    input  logic [width-1:0] ref_rdata,
    output logic             core_rst,
    output logic             core_running,
    output logic [width-1:0] core_squiggle,
    output logic [width-1:0] core_rword,
    output logic [31:0]      core_ref_len,
    input  logic [width-1:0] core_minval,
    input  logic [31:0]      core_position,
    input  logic             core_done,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [width-1:0] result_minval,
    output logic [31:0]      result_position,
    output logic             busy,
    output logic             err_len
);

    localparam int IDX_W = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;
    localparam int CNT_W = $clog2(SQG_SIZE + 1);
    localparam logic [CNT_W-1:0] LD_LAST = CNT_W'(SQG_SIZE - 1);
    localparam logic [31:0]      SQG_LEN = 32'(SQG_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_REPORT
    } state_t;

    typedef struct packed {
        logic [width-1:0] minval;
        logic [31:0]      position;
    } result_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ld_cnt;
    logic [31:0]      t;
    logic [31:0]      t_m1;
    logic [IDX_W-1:0] sq_idx;
    logic             drain_cnt;
    result_t          result_q;
    logic [width-1:0] qbuf [SQG_SIZE];
    logic             start_ok;
    logic             start_bad;
    logic             ld_hs;

    assign start_ok  = (state == S_IDLE) && start && (ref_len_in != 32'd0);
    assign start_bad = (state == S_IDLE) && start && (ref_len_in == 32'd0);
    assign ld_hs     = (state == S_LOAD) && sqg_valid;

    // Column t of RUN feeds query/reference sample t-1; t=0 is the core's priming cycle.
    assign t_m1   = t - 32'd1;
    assign sq_idx = t_m1[IDX_W-1:0];

    assign result_minval   = result_q.minval;
    assign result_position = result_q.position;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and combinational outputs; core_running drops in the same cycle core_done rises.
    always_comb begin
        state_nxt     = state;
        sqg_ready     = 1'b0;
        ref_en        = 1'b0;
        ref_addr      = 32'd0;
        core_rst      = 1'b0;
        core_running  = 1'b0;
        core_squiggle = '0;
        core_rword    = '0;
        result_valid  = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                sqg_ready = 1'b1;
                if (ld_hs && (ld_cnt == LD_LAST)) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                core_rst  = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                core_running = !core_done;
                ref_en       = (t < core_ref_len);
                ref_addr     = t;
                if (t != 32'd0) begin
                    if (t_m1 < SQG_LEN)      core_squiggle = qbuf[sq_idx];
                    if (t_m1 < core_ref_len) core_rword    = ref_rdata;
                end
                if (core_done) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt) state_nxt = S_REPORT;
            end
            S_REPORT: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, latched length, error pulse and result capture at the end of DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt       <= '0;
            t            <= 32'd0;
            drain_cnt    <= 1'b0;
            core_ref_len <= 32'd0;
            err_len      <= 1'b0;
            result_q     <= '0;
        end else begin
            err_len <= start_bad;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        core_ref_len <= ref_len_in;
                        ld_cnt       <= '0;
                        t            <= 32'd0;
                        drain_cnt    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_hs) ld_cnt <= ld_cnt + 1'b1;
                end
                S_CLEAR: begin
                    t <= 32'd0;
                end
                S_RUN: begin
                    t         <= t + 32'd1;
                    drain_cnt <= 1'b0;
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        result_q.minval   <= core_minval;
                        result_q.position <= core_position;
                    end
                end
                default: ;
            endcase
        end
    end

    // Query buffer write; contents are not reset since every search reloads them.
    always_ff @(posedge clk) begin
        if (ld_hs) qbuf[ld_cnt[IDX_W-1:0]] <= sqg_data;
    end

endmodule

// File: tb/tb_dtw_query_sequencer.sv
`timescale 1ns/1ps
module tb_dtw_query_sequencer;

    localparam int SQG  = 4;
    localparam int W    = 16;
    localparam int MAXR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] ref_len_in;
    logic        sqg_valid;
    logic        sqg_ready;
    logic [15:0] sqg_data;
    logic        ref_en;
    logic [31:0] ref_addr;
    logic [15:0] ref_rdata;
    logic        core_rst;
    logic        core_running;
    logic [15:0] core_squiggle;
    logic [15:0] core_rword;
    logic [31:0] core_ref_len;
    logic [15:0] core_minval;
    logic [31:0] core_position;
    logic        core_done;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_minval;
    logic [31:0] result_position;
    logic        busy;
    logic        err_len;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [47:0] exp_q[$];
    logic [15:0] q_cur   [SQG];
    logic [15:0] ref_mem [MAXR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dtw_query_sequencer #(.width(W), .SQG_SIZE(SQG)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_len_in(ref_len_in),
        .sqg_valid(sqg_valid), .sqg_ready(sqg_ready), .sqg_data(sqg_data),
        .ref_en(ref_en), .ref_addr(ref_addr), .ref_rdata(ref_rdata),
        .core_rst(core_rst), .core_running(core_running),
        .core_squiggle(core_squiggle), .core_rword(core_rword), .core_ref_len(core_ref_len),
        .core_minval(core_minval), .core_position(core_position), .core_done(core_done),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_minval(result_minval), .result_position(result_position),
        .busy(busy), .err_len(err_len)
    );

    // Subsequence DTW: free start column, result = {min last-row cost, first column reaching it}.
    function automatic logic [47:0] dtw_golden(input logic [15:0] q[SQG], input logic [15:0] r[MAXR], input int n);
        int d[SQG][MAXR];
        int c, m, best, bpos;
        for (int i = 0; i < SQG; i++) begin
            for (int j = 0; j < n; j++) begin
                c = (q[i] > r[j]) ? int'(q[i]) - int'(r[j]) : int'(r[j]) - int'(q[i]);
                if (i == 0) d[i][j] = c;
                else if (j == 0) d[i][j] = d[i-1][0] + c;
                else begin
                    m = d[i-1][j];
                    if (d[i][j-1] < m) m = d[i][j-1];
                    if (d[i-1][j-1] < m) m = d[i-1][j-1];
                    d[i][j] = c + m;
                end
            end
        end
        best = d[SQG-1][0];
        bpos = 0;
        for (int j = 1; j < n; j++) begin
            if (d[SQG-1][j] < best) begin
                best = d[SQG-1][j];
                bpos = j;
            end
        end
        return {best[15:0], 32'(bpos)};
    endfunction

    function automatic logic [150:0] all_outs();
        return {sqg_ready, ref_en, ref_addr, core_rst, core_running, core_squiggle, core_rword,
                core_ref_len, result_valid, result_minval, result_position, busy, err_len};
    endfunction

    // Reference memory: one-cycle read latency, garbage when not enabled.
    always @(posedge clk) begin
        if (ref_en) ref_rdata <= ref_mem[ref_addr[3:0]];
        else        ref_rdata <= 16'hdead;
    end

    // Behavioural core: captures what it is fed and computes DTW on the captured samples.
    logic [31:0] cm_cnt;
    logic [31:0] cm_m1;
    logic        cm_fin;
    logic [15:0] cm_q [SQG];
    logic [15:0] cm_r [MAXR];
    assign cm_m1     = cm_cnt - 32'd1;
    assign core_done = (cm_cnt == 32'(SQG) + core_ref_len + 32'd1);

    always @(posedge clk) begin
        if (rst || core_rst) begin
            cm_cnt <= 32'd0;
            cm_fin <= 1'b0;
            if (rst) begin
                core_minval   <= 16'd0;
                core_position <= 32'd0;
            end
        end else begin
            if (core_running) begin
                cm_cnt <= cm_cnt + 32'd1;
                if (cm_cnt >= 1 && cm_cnt <= SQG) cm_q[cm_m1[1:0]] <= core_squiggle;
                if (cm_cnt >= 1 && cm_cnt <= core_ref_len && cm_cnt <= MAXR) cm_r[cm_m1[3:0]] <= core_rword;
            end
            if (core_done && !cm_fin) begin
                cm_fin <= 1'b1;
                {core_minval, core_position} <= dtw_golden(cm_q, cm_r, int'(core_ref_len));
            end
        end
    end

    task automatic set_dataset(input int which);
        for (int j = 0; j < MAXR; j++) ref_mem[j] = 16'd0;
        if (which == 0) begin
            q_cur[0] = 3; q_cur[1] = 5; q_cur[2] = 7; q_cur[3] = 9;
            ref_mem[0] = 9; ref_mem[1] = 3; ref_mem[2] = 5; ref_mem[3] = 7; ref_mem[4] = 9; ref_mem[5] = 1;
        end else begin
            q_cur[0] = 10; q_cur[1] = 2; q_cur[2] = 8; q_cur[3] = 4;
            ref_mem[0] = 1; ref_mem[1] = 10; ref_mem[2] = 3; ref_mem[3] = 8; ref_mem[4] = 5;
        end
    endtask

    // Issues start, pushes the expected result, feeds the query; returns at the negedge after the last handshake.
    task automatic drive_search(input int len, input bit toggle, output int accepted, output int start_cyc);
        int k;
        int n;
        k = 0;
        n = 0;
        @(negedge clk);
        start      = 1'b1;
        ref_len_in = len;
        start_cyc  = cyc + 1;
        exp_q.push_back(dtw_golden(q_cur, ref_mem, len));
        while (k < SQG && n < 200) begin
            @(negedge clk);
            start     = 1'b0;
            sqg_valid = toggle ? ((n % 2) == 0) : 1'b1;
            sqg_data  = q_cur[k];
            if (sqg_valid && sqg_ready) k++;
            n++;
        end
        @(negedge clk);
        sqg_valid = 1'b0;
        accepted  = k;
    endtask

    task automatic wait_result(output int seen_cyc, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            if (result_valid) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        seen_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (all_outs() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        start = 1'b1; ref_len_in = 0;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_pulse: err_len=%b busy=%b, want err_len=1 busy=0", err_len, busy);
        end
        @(negedge clk);
        tests_run++;
        if (err_len !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_after: err_len=%b busy=%b, want 0 0", err_len, busy);
        end
    endtask

    task automatic test_nominal();
        int acc, sc, seen;
        bit ok;
        logic [47:0] exp;
        set_dataset(0);
        result_ready = 1'b1;
        drive_search(6, 1'b0, acc, sc);
        tests_run++;
        if (core_ref_len !== 32'd6) begin
            tests_failed++;
            $display("FAIL nominal_ref_len: got %0d, want 6", core_ref_len);
        end
        wait_result(seen, ok);
        tests_run++;
        if (!ok || (seen - sc) != 19) begin
            tests_failed++;
            $display("FAIL nominal_latency: got %0d (valid=%b), want 19", seen - sc, ok);
        end
        tests_run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
        if ({result_minval, result_position} !== exp) begin
            tests_failed++;
            $display("FAIL nominal_result: got %0d@%0d, want %0d@%0d", result_minval, result_position, exp[47:32], exp[31:0]);
        end
        tests_run++;
        if ({result_minval, result_position} !== {16'd0, 32'd4}) begin
            tests_failed++;
            $display("FAIL nominal_exact_match: got %0d@%0d, want 0@4", result_minval, result_position);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL nominal_return_idle: busy=%b valid=%b, want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_load_backpressure();
        int acc, sc, seen;
        bit ok;
        logic [47:0] exp;
        set_dataset(1);
        drive_search(5, 1'b1, acc, sc);
        tests_run++;
        if (acc != SQG || sqg_ready !== 1'b0 || core_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_load_end: accepted=%0d sqg_ready=%b core_rst=%b, want 4 0 1", acc, sqg_ready, core_rst);
        end
        @(negedge clk);
        tests_run++;
        if (core_rst !== 1'b0 || sqg_ready !== 1'b0 || core_running !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_clear_once: core_rst=%b sqg_ready=%b running=%b, want 0 0 1", core_rst, sqg_ready, core_running);
        end
        wait_result(seen, ok);
        tests_run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
        if (!ok || {result_minval, result_position} !== exp) begin
            tests_failed++;
            $display("FAIL bp_result: got %0d@%0d (valid=%b), want %0d@%0d", result_minval, result_position, ok, exp[47:32], exp[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_stream_alignment();
        int acc, sc, seen, t, en_cnt;
        bit ok, done_seen;
        logic [15:0] esq, erw;
        logic [47:0] exp;
        set_dataset(0);
        drive_search(6, 1'b0, acc, sc);
        t = 0; en_cnt = 0; done_seen = 1'b0;
        while (!done_seen && t < 64) begin
            @(negedge clk);
            if (core_done) begin
                done_seen = 1'b1;
                tests_run++;
                if (core_running !== 1'b0 || t != SQG + 6 + 1) begin
                    tests_failed++;
                    $display("FAIL align_done: running=%b run_cycles=%0d, want 0 and 11", core_running, t);
                end
            end else begin
                esq = (t >= 1 && t - 1 < SQG) ? q_cur[t-1] : 16'd0;
                erw = (t >= 1 && t - 1 < 6) ? ref_mem[t-1] : 16'd0;
                tests_run++;
                if (core_running !== 1'b1 || ref_addr !== 32'(t) || ref_en !== (t < 6) ||
                    core_squiggle !== esq || core_rword !== erw) begin
                    tests_failed++;
                    $display("FAIL align_t%0d: run=%b addr=%0d en=%b sq=%0d rw=%0d, want 1 %0d %b %0d %0d",
                             t, core_running, ref_addr, ref_en, core_squiggle, core_rword, t, (t < 6), esq, erw);
                end
                if (ref_en) en_cnt++;
                t++;
            end
        end
        tests_run++;
        if (en_cnt != 6) begin
            tests_failed++;
            $display("FAIL align_ref_en_count: got %0d, want 6", en_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (core_running !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL align_drain%0d: running=%b valid=%b busy=%b, want 0 0 1", i, core_running, result_valid, busy);
            end
        end
        @(negedge clk);
        wait_result(seen, ok);
        tests_run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
        if (!ok || {result_minval, result_position} !== exp) begin
            tests_failed++;
            $display("FAIL align_result: got %0d@%0d (valid=%b), want %0d@%0d", result_minval, result_position, ok, exp[47:32], exp[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_result_hold();
        int acc, sc, seen;
        bit ok;
        logic [47:0] exp, snap;
        set_dataset(1);
        result_ready = 1'b0;
        drive_search(5, 1'b0, acc, sc);
        wait_result(seen, ok);
        tests_run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
        if (!ok || {result_minval, result_position} !== exp) begin
            tests_failed++;
            $display("FAIL hold_result: got %0d@%0d (valid=%b), want %0d@%0d", result_minval, result_position, ok, exp[47:32], exp[31:0]);
        end
        snap = {result_minval, result_position};
        for (int i = 0; i < 10; i++) begin
            start      = (i == 3) || (i == 6);
            ref_len_in = (i == 6) ? 32'd0 : 32'd6;
            @(negedge clk);
            tests_run++;
            if (result_valid !== 1'b1 || {result_minval, result_position} !== snap || err_len !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h err=%b busy=%b, want 1 %h 0 1", i, result_valid,
                         {result_minval, result_position}, err_len, busy, snap);
            end
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: busy=%b valid=%b, want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_mid_run_reset();
        int acc, sc, seen;
        bit ok;
        logic [47:0] exp;
        set_dataset(0);
        drive_search(6, 1'b0, acc, sc);
        repeat (4) @(negedge clk);
        tests_run++;
        if (ref_addr !== 32'd3 || core_running !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_t3: addr=%0d running=%b, want 3 1", ref_addr, core_running);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (all_outs() !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %h, want 0", all_outs());
        end
        rst = 1'b0;
        exp_q.delete();
        drive_search(6, 1'b0, acc, sc);
        wait_result(seen, ok);
        tests_run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
        if (!ok || {result_minval, result_position} !== exp) begin
            tests_failed++;
            $display("FAIL midrst_rerun: got %0d@%0d (valid=%b), want %0d@%0d", result_minval, result_position, ok, exp[47:32], exp[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int acc, sc, seen;
        bit ok;
        logic [47:0] exp;
        for (int s = 0; s < 2; s++) begin
            set_dataset(1 - s);
            drive_search((s == 0) ? 5 : 6, 1'b0, acc, sc);
            wait_result(seen, ok);
            tests_run++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
            if (!ok || {result_minval, result_position} !== exp || (seen - sc) != ((s == 0) ? 18 : 19)) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got %0d@%0d lat=%0d (valid=%b), want %0d@%0d lat=%0d", s, result_minval, result_position,
                         seen - sc, ok, exp[47:32], exp[31:0], (s == 0) ? 18 : 19);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ref_len_in = 32'd0;
        sqg_valid = 1'b0; sqg_data = 16'd0; result_ready = 1'b1;
        set_dataset(0);
        test_reset();
        test_zero_length();
        test_nominal();
        test_load_backpressure();
        test_stream_alignment();
        test_result_hold();
        test_mid_run_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
